fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the single-cycle instruction memory for the core.
- Owns the fetch PC and drives the memory word address every cycle.
- Captures the combinational read data into a small in-order queue and hands {pc, instr} to decode over a valid/ready handshake.
- Handles start, halt and control-flow redirects (branch/jump/trap) with a full queue flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset; bits [1:0] must be 0.
- DEPTH, 2, queue entries; legal values 2, 4 or 8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leave IDLE and begin fetching.
- halt  in  1  level; stop issuing new fetches.
- redirect_valid  in  1  flush the queue and load redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- imem_addr  out  32  byte address to instruction memory; always equals fetch_pc.
- imem_data  in  32  word read from memory, valid in the same cycle as imem_addr.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- state  out  2  00 IDLE, 01 RUN, 10 STOPPED.

Behaviour:
- Reset (async assert, sync release) sets:
  - state = IDLE
  - fetch_pc = RESET_PC, so imem_addr = RESET_PC
  - queue count = 0, so out_valid = 0
  - out_pc and out_instr read as 0 while the queue is empty
- Definitions:
  - deq = out_valid && out_ready.
  - push_ok = (count < DEPTH) || deq, i.e. a push is allowed when full if a dequeue happens the same cycle.
- Push: when push_ok, write {fetch_pc, imem_data} at the tail and set fetch_pc += 4.
  - fetch_pc wraps mod 2^32: 32'hFFFF_FFFC becomes 0.
  - An entry pushed in cycle N is visible on out_* in cycle N+1 if the queue was empty; fetch-to-decode latency is 1 cycle.
- Queue:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits and count of log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - Strictly in order; no entry is dropped except by a flush.
- Redirect (any state) takes priority over push, halt and start:
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - count and pointers are cleared; no push happens that cycle.
  - A deq in the same cycle counts as accepted by decode; all other entries are discarded.
  - Next state: IDLE stays IDLE; RUN stays RUN; STOPPED goes to RUN.
- State machine:
  - IDLE: no push. start goes to RUN, with the first push in the next cycle. halt is ignored.
  - RUN: push whenever push_ok and no redirect. halt goes to STOPPED, with no push in that same cycle. start is ignored.
  - STOPPED: no push; the queue drains normally through deq. Exit only by redirect_valid. Deassertion of halt alone does not resume.
- Priority when halt and redirect are both high in RUN: redirect wins, state stays RUN, and halt is re-sampled next cycle.
- imem_addr is purely fetch_pc, so memory address to data is a combinational path into the queue write port with no extra pipeline stage.
- Async reset mid-operation: all state returns to reset values immediately and in-flight entries are lost.

Test Plan:
- Reset/start: RESET_PC=0, memory word i = 32'h1000_0000+i. Pulse start, hold out_ready=1. Required: out_valid rises 2 cycles after start; out_pc sequence 0,4,8,...; out_instr 0x10000000, 0x10000001, ...; one entry per cycle.
- Backpressure: out_ready=0 for 6 cycles. Required: count saturates at DEPTH=2 with out_pc 0 then 4, fetch_pc holds at 8. Raise out_ready: strictly consecutive PCs, no gaps or duplicates.
- Redirect: in RUN with 2 entries queued, pulse redirect_valid with redirect_pc=32'h0000_0103. Required: the next out_valid shows out_pc=0x100 with mem[0x40]; flushed PCs never appear.
- Halt/resume: assert halt in RUN. Required: state=STOPPED the next cycle, the queue drains, out_valid=0. Dropping halt does nothing; redirect to 0x20 resumes with out_pc=0x20.
- Wrap: redirect to 32'hFFFF_FFF8 with out_ready=1. Required: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-stream: drop rst_n between clock edges with 2 entries queued. Required: out_valid=0, state=IDLE and imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives the imem address
// and queues {pc, instr} pairs for decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, halt         leave IDLE / stop issuing fetches (level)
//   redirect_valid/pc   flush the queue and load a new fetch PC
//   imem_addr/data      single-cycle instruction memory interface
//   out_valid/ready     decode handshake; out_pc/out_instr carry the head
//   state               00 IDLE, 01 RUN, 10 STOPPED
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [1:0]  state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    STOPPED = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic deq;
  logic push_ok;
  logic push;

  // Low address bits of a redirect target are dropped on purpose.
  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

  assign out_valid = (cnt_q != '0);
  assign deq       = out_valid && out_ready;
  // A full queue may still accept a push when the head leaves this cycle.
  assign push_ok   = (cnt_q < FULL) || deq;

  assign imem_addr = fetch_pc_q;
  assign state     = state_q;
  assign out_pc    = out_valid ? pc_mem_q[rd_q]    : '0;
  assign out_instr = out_valid ? instr_mem_q[rd_q] : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    if (redirect_valid) begin
      // Flush wins over everything; a same-cycle deq was still taken.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      if (state_q == STOPPED) state_d = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (halt) state_d = STOPPED;
          else      push    = push_ok;
        end
        default: ;
      endcase
      if (push) begin
        wr_d       = wr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (deq) rd_d = rd_q + 1'b1;
      if (push && !deq)      cnt_d = cnt_q + 1'b1;
      else if (!push && deq) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_q]    <= fetch_pc_q;
      instr_mem_q[wr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  int          m_st;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_st = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] ev, ep, ei;
    ev = (mq.size() != 0) ? 32'd1 : 32'd0;
    ep = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
    ei = (mq.size() != 0) ? mq[0][31:0]  : 32'd0;
    check({tag, "_valid"}, {31'd0, out_valid}, ev);
    check({tag, "_pc"},    out_pc,    ep);
    check({tag, "_instr"}, out_instr, ei);
    check({tag, "_addr"},  imem_addr, m_pc);
    check({tag, "_state"}, {30'd0, state}, 32'(m_st));
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit deq;
    deq = (mq.size() != 0) && out_ready;
    if (deq) void'(mq.pop_front());
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      if (m_st == 2) m_st = 1;
    end else if (m_st == 0) begin
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      if (halt) m_st = 2;
      else if (mq.size() < DEPTH) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input string tag, input bit s, input bit h,
                     input bit r, input logic [31:0] rp, input bit rdy);
    @(negedge clk);
    start          = s;
    halt           = h;
    redirect_valid = r;
    redirect_pc    = rp;
    out_ready      = rdy;
    #1;
    check_outputs(tag);
    model_step();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; halt = 0; redirect_valid = 0;
    redirect_pc = '0; out_ready = 0;
    model_reset();
    #3;
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    #9 rst_n = 1'b1;

    cyc("idle", 0, 1, 0, 0, 1);
    cyc("start", 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc("stream", 0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) cyc("bp", 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc("bp_rel", 0, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) cyc("fill", 0, 0, 0, 0, 0);
    cyc("redir", 0, 0, 1, 32'h0000_0103, 0);
    for (int i = 0; i < 4; i++) cyc("post_redir", 0, 0, 0, 0, 1);
    check("redir_pc_seen", out_pc, 32'h0000_0108);

    cyc("halt", 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("drain", 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("unhalt", 0, 0, 0, 0, 1);
    cyc("resume", 0, 0, 1, 32'h0000_0020, 1);
    for (int i = 0; i < 3; i++) cyc("post_res", 0, 0, 0, 0, 1);

    cyc("wrap_r", 0, 0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 6; i++) cyc("wrap", 0, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) cyc("pre_arst", 0, 0, 0, 0, 0);
    check("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_state", {30'd0, state}, 32'd0);
    check("arst_addr", imem_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc("after_arst", 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(9) == 0),
          ($urandom_range(9) == 0),
          ($urandom_range(19) == 0),
          $urandom(),
          ($urandom_range(9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
